// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcode/funct constants,
// the issue packet layout and an immediate sign-extension helper.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_pkt_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of one OP / OP-IMM instruction into an issue packet.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output issue_pkt_t  pkt_o,
  output logic        uses_rs2_o
);

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        legal;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign f3     = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign f7     = instr_i[31:25];

  // x0 always reads as zero whatever the register file returns
  assign op_a = (rs1 == 5'd0) ? 32'd0 : rs1_data_i;
  assign op_b = (rs2 == 5'd0) ? 32'd0 : rs2_data_i;

  assign uses_rs2_o = (opcode == OPC_OP);

  always_comb begin
    pkt_o        = '0;
    legal        = 1'b0;
    pkt_o.in1    = op_a;
    pkt_o.funct3 = f3;
    pkt_o.rd     = rd;
    case (opcode)
      OPC_OP: begin
        pkt_o.in2    = op_b;
        pkt_o.shamt  = op_b[4:0];
        pkt_o.funct7 = f7;
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        pkt_o.in2 = sext12(instr_i[31:20]);
        case (f3)
          F3_SLL: begin
            pkt_o.shamt  = rs2;
            pkt_o.funct7 = f7;
            legal        = (f7 == F7_BASE);
          end
          F3_SR: begin
            pkt_o.shamt  = rs2;
            pkt_o.funct7 = f7;
            legal        = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          // immediate bits must never be mistaken for the SUB selector
          default: begin
            pkt_o.shamt  = 5'd0;
            pkt_o.funct7 = F7_BASE;
            legal        = 1'b1;
          end
        endcase
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    pkt_o.illegal = ~legal;
    pkt_o.we      = legal && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: valid/ready handshake, optional two-entry skid buffer and
// a busy scoreboard that stalls RAW hazards until the destination is written back.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_in1,
  output logic [XLEN-1:0] out_in2,
  output logic [4:0]      out_shamt,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  issue_pkt_t  dec_pkt;
  issue_pkt_t  out_q, out_d;
  issue_pkt_t  skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] busy_q, busy_d;
  logic        uses_rs2;
  logic        hazard;
  logic        space;
  logic        accept;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_issue_decode u_decode (
    .instr_i    (in_instr),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .pkt_o      (dec_pkt),
    .uses_rs2_o (uses_rs2)
  );

  // a register being cleared by writeback this cycle still counts as busy
  assign hazard   = busy_q[rs1_addr] | (uses_rs2 & busy_q[rs2_addr]);
  assign space    = SKID_EN ? ~skid_valid_q : (~out_valid_q | out_ready);
  assign in_ready = ~rst & ~hazard & space;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_valid_q && !out_ready) begin
      if (accept) begin
        skid_d       = dec_pkt;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else if (skid_valid_q) begin
      // skid is full so nothing can be accepted; drain it first to keep order
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else begin
      out_valid_d = accept;
      out_d       = accept ? dec_pkt : out_q;
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      out_valid_d  = out_valid_d;
    end
  end

  // set beats clear when both target the same register
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept && dec_pkt.we) begin
      busy_d[dec_pkt.rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
    if (flush) begin
      busy_d = 32'd0;
    end else begin
      busy_d = busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      busy_q       <= 32'd0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_in1     = out_q.in1;
  assign out_in2     = out_q.in2;
  assign out_shamt   = out_q.shamt;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rd      = out_q.rd;
  assign out_we      = out_q.we;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, directed hazard/skid/flush
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [4:0]  out_shamt;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  logic [31:0] regs [32];
  issue_pkt_t  dut_pkt;
  issue_pkt_t  model_q [$];
  logic [31:0] busy_m;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [31:0] instr;
    issue_pkt_t  exp;
  } vec_t;

  vec_t vecs [10];

  localparam logic [31:0] V1 = 32'h1234_5678;
  localparam logic [31:0] V2 = 32'h8765_4321;

  alu_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2), .out_shamt(out_shamt),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
    .out_we(out_we), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dut_pkt  = {out_in1, out_in2, out_shamt, out_funct3, out_funct7, out_rd, out_we, out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic we, input logic ill);
    vec_t v;
    v.instr = ins;
    v.exp   = {a, b, sh, f3, f7, rd, we, ill};
    return v;
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic issue_pkt_t ref_decode(input logic [31:0] ins);
    issue_pkt_t p;
    logic [31:0] a, b, imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        ok;
    a   = (ins[19:15] == 5'd0) ? 32'd0 : regs[ins[19:15]];
    b   = (ins[24:20] == 5'd0) ? 32'd0 : regs[ins[24:20]];
    imm = 32'($signed(ins[31:20]));
    f7  = ins[31:25];
    f3  = ins[14:12];
    p   = '0;
    p.in1 = a;
    p.funct3 = f3;
    p.rd = ins[11:7];
    ok = 1'b0;
    if (ins[6:0] == 7'h33) begin
      p.in2 = b; p.shamt = b[4:0]; p.funct7 = f7;
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (ins[6:0] == 7'h13) begin
      p.in2 = imm;
      if (f3 == 3'd1) begin
        p.shamt = ins[24:20]; p.funct7 = f7; ok = (f7 == 7'h00);
      end else if (f3 == 3'd5) begin
        p.shamt = ins[24:20]; p.funct7 = f7; ok = (f7 == 7'h00) || (f7 == 7'h20);
      end else begin
        ok = 1'b1;
      end
    end
    p.illegal = !ok;
    p.we = ok && (p.rd != 5'd0);
    return p;
  endfunction

  function automatic logic model_ready();
    logic haz;
    haz = busy_m[in_instr[19:15]] || ((in_instr[6:0] == 7'h33) && busy_m[in_instr[24:20]]);
    return !rst && (model_q.size() < 2) && !haz;
  endfunction

  task automatic settle();
    #1;
    chk("in_ready", 128'(in_ready), 128'(model_ready()));
    chk("out_valid", 128'(out_valid), 128'(model_q.size() > 0));
    if (model_q.size() > 0) chk("out_pkt", 128'(dut_pkt), 128'(model_q[0]));
  endtask

  task automatic clk_step();
    logic acc;
    issue_pkt_t p;
    acc = in_valid && model_ready() && !flush;
    p = ref_decode(in_instr);
    if (rst || flush) begin
      model_q.delete();
      busy_m = 32'd0;
    end else begin
      if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
      if (wb_valid) busy_m[wb_rd] = 1'b0;
      if (acc) begin
        model_q.push_back(p);
        if (p.we) busy_m[p.rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_busy();
    int s;
    s = int'($urandom_range(0, 31));
    for (int k = 0; k < 32; k++) begin
      if (busy_m[(s + k) % 32]) return 5'((s + k) % 32);
    end
    return 5'(s);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sel;
    sel = int'($urandom_range(0, 7));
    op  = (sel < 4) ? 7'h13 : (sel < 7) ? 7'h33 : 7'($urandom);
    sel = int'($urandom_range(0, 3));
    f7  = (sel == 1) ? 7'h20 : (sel == 2) ? 7'($urandom) : 7'h00;
    f3  = 3'($urandom);
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), op};
  endfunction

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0;
    settle(); clk_step();
    flush = 1'b0;
  endtask

  initial begin
    int n_acc;
    int got_n;
    logic [4:0] got [3];
    logic [31:0] ins;
    n_checks = 0; n_fail = 0;
    busy_m = 32'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;

    // Reset: held for two cycles, in_ready low, data outputs cleared
    @(posedge clk); #1;
    settle();
    chk("rst_data", 128'(dut_pkt), 128'd0);
    clk_step();
    rst = 1'b0;
    settle();
    chk("ready_after_rst", 128'(in_ready), 128'd1);
    clk_step();

    vecs[0] = mk(32'hFFB0_0093, 32'd0, 32'hFFFF_FFFB, 5'd0, 3'd0, 7'h00, 5'd1, 1'b1, 1'b0);
    vecs[1] = mk(32'h4072_D213, V1, 32'h0000_0407, 5'd7, 3'd5, 7'h20, 5'd4, 1'b1, 1'b0);
    vecs[2] = mk(32'h4032_9213, V1, 32'h0000_0403, 5'd3, 3'd1, 7'h20, 5'd4, 1'b0, 1'b1);
    vecs[3] = mk(32'h0000_A303, V1, 32'd0, 5'd0, 3'd2, 7'h00, 5'd6, 1'b0, 1'b1);
    vecs[4] = mk(32'h0020_8033, V1, V2, 5'd1, 3'd0, 7'h00, 5'd0, 1'b0, 1'b0);
    vecs[5] = mk(32'h4020_81B3, V1, V2, 5'd1, 3'd0, 7'h20, 5'd3, 1'b1, 1'b0);
    vecs[6] = mk(32'h4020_91B3, V1, V2, 5'd1, 3'd1, 7'h20, 5'd3, 1'b0, 1'b1);
    vecs[7] = mk(32'h8000_F393, V1, 32'hFFFF_F800, 5'd0, 3'd7, 7'h00, 5'd7, 1'b1, 1'b0);
    vecs[8] = mk(32'h4000_D433, V1, 32'd0, 5'd0, 3'd5, 7'h20, 5'd8, 1'b1, 1'b0);
    vecs[9] = mk(32'h0240_D493, V1, 32'h0000_0024, 5'd4, 3'd5, 7'h01, 5'd9, 1'b0, 1'b1);

    // Decode table: each vector on an empty, flushed stage
    for (int i = 0; i < 10; i++) begin
      do_flush();
      ins = vecs[i].instr;
      regs[0] = 32'hDEAD_BEEF;
      regs[ins[24:20]] = V2;
      regs[ins[19:15]] = V1;
      in_instr = ins; in_valid = 1'b1; out_ready = 1'b1;
      settle();
      chk($sformatf("vec%0d_ready", i), 128'(in_ready), 128'd1);
      clk_step();
      in_valid = 1'b0;
      settle();
      chk($sformatf("vec%0d_pkt", i), 128'(dut_pkt), 128'(vecs[i].exp));
      clk_step();
    end

    // RAW hazard: SUB x3,x1,x2 waits for writeback of x1, no same-cycle bypass
    do_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFB0_0093;
    settle(); clk_step();
    in_instr = 32'h4020_81B3;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("raw_stall", 128'(in_ready), 128'd0); clk_step();
    end
    wb_valid = 1'b1; wb_rd = 5'd1;
    settle(); chk("no_bypass", 128'(in_ready), 128'd0); clk_step();
    wb_valid = 1'b0;
    settle(); chk("raw_release", 128'(in_ready), 128'd1); clk_step();
    in_valid = 1'b0;
    settle();
    chk("sub_f7", 128'({out_valid, out_funct7, out_rd}), 128'({1'b1, 7'h20, 5'd3}));
    clk_step();

    // Skid: output stalled for 3 cycles, ADDI x1..x3 back to back
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      in_instr = {12'(n_acc + 1), 5'd0, 3'd0, 5'(n_acc + 1), 7'h13};
      settle();
      if (in_ready) n_acc++;
      clk_step();
    end
    chk("skid_accepted", 128'(n_acc), 128'd2);
    out_ready = 1'b1; got_n = 0;
    for (int i = 0; i < 10 && got_n < 3; i++) begin
      in_valid = (n_acc < 3);
      in_instr = {12'(n_acc + 1), 5'd0, 3'd0, 5'(n_acc + 1), 7'h13};
      settle();
      if (out_valid) begin got[got_n] = out_rd; got_n++; end
      if (in_valid && in_ready) n_acc++;
      clk_step();
    end
    in_valid = 1'b0;
    chk("skid_count", 128'(got_n), 128'd3);
    if (got_n == 3) chk("skid_order", 128'({got[0], got[1], got[2]}), 128'({5'd1, 5'd2, 5'd3}));

    // Flush with output valid and skid full; same-cycle accept is dropped
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0010_0093; settle(); clk_step();
    in_instr = 32'h0020_0113; settle(); clk_step();
    flush = 1'b1; in_instr = 32'h0050_0293; settle(); clk_step();
    flush = 1'b0; in_instr = 32'h0020_84B3;
    settle();
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1; clk_step();
    in_valid = 1'b0;
    settle(); chk("after_flush_rd", 128'(out_rd), 128'd9); clk_step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = pick_busy();
      in_instr  = rand_instr();
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = $urandom;
      settle();
      chk("rs_addr", 128'({rs1_addr, rs2_addr}), 128'({in_instr[19:15], in_instr[24:20]}));
      clk_step();
    end

    // Reset mid-operation clears everything including data outputs
    flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0093;
    settle(); clk_step();
    rst = 1'b1; settle(); clk_step();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    chk("midrst_data", 128'(dut_pkt), 128'd0);
    clk_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
